// File: rtl/or4_behavior.sv
// Four-input OR primitive with a registered result, a rise pulse
// and a saturating activity counter.
module or4_behavior #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_f,
  output logic [WIDTH-1:0] o_f_r,
  output logic             o_any,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] f_r_q, f_r_d;
  logic             any_q, any_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_f   = i_a | i_b | i_c | i_d;
  assign o_any = |o_f;

  // Clear wins over both increment and edge detection.
  always_comb begin
    f_r_d  = o_f;
    any_d  = o_any;
    rise_d = o_any & ~any_q;
    cnt_d  = cnt_q;
    if (o_any && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (i_clr) begin
      any_d  = 1'b0;
      rise_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_r_q  <= '0;
      any_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      f_r_q  <= f_r_d;
      any_q  <= any_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_f_r     = f_r_q;
  assign o_rise    = rise_q;
  assign o_hit_cnt = cnt_q;

endmodule

// File: tb/tb_or4_behavior.sv
// Bench for or4_behavior: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_or4_behavior;

  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [W-1:0]  a, b, c, d;
  logic [W-1:0]  f, f_r;
  logic          any, rise;
  logic [CW-1:0] cnt;

  logic          a1, b1, c1, d1;
  logic          f1, f1_r, any1, rise1;
  logic [7:0]    cnt1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_fr = '0;
  logic         m_any = 1'b0;
  logic         m_rise = 1'b0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  or4_behavior #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d),
    .i_clr(clr),
    .o_f(f), .o_f_r(f_r), .o_any(any),
    .o_rise(rise), .o_hit_cnt(cnt)
  );

  or4_behavior #(.WIDTH(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a(a1), .i_b(b1), .i_c(c1), .i_d(d1),
    .i_clr(clr),
    .o_f(f1), .o_f_r(f1_r), .o_any(any1),
    .o_rise(rise1), .o_hit_cnt(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the spec says each clocked output must hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fr   <= '0;
      m_any  <= 1'b0;
      m_rise <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_fr <= a | b | c | d;
      if (clr) begin
        m_any  <= 1'b0;
        m_rise <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_any  <= ((a | b | c | d) != 0);
        m_rise <= ((a | b | c | d) != 0) && !m_any;
        if ((a | b | c | d) != 0)
          m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_f", 32'(f), 32'(a | b | c | d));
    chk("cmp_any", 32'(any), 32'((a | b | c | d) != 0));
    chk("cmp_f_r", 32'(f_r), 32'(m_fr));
    chk("cmp_rise", 32'(rise), 32'(m_rise));
    chk("cmp_cnt", 32'(cnt), 32'(m_cnt));
    chk("cmp_f1", 32'(f1), 32'(a1 | b1 | c1 | d1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic zero_ops();
    a = '0; b = '0; c = '0; d = '0;
  endtask

  initial begin
    int rises;
    logic [3:0] code;
    rst_n = 1'b0;
    clr   = 1'b0;
    zero_ops();
    {a1, b1, c1, d1} = 4'b0000;

    for (int i = 0; i <= 16; i++) begin
      code = 4'(i);
      {a1, b1, c1, d1} = code;
      #1;
      chk("sweep_f", 32'(f1), 32'(i % 16 != 0));
      chk("sweep_any", 32'(any1), 32'(i % 16 != 0));
      #999;
    end

    chk("rst_f_r", 32'(f_r), 32'h0);
    chk("rst_rise", 32'(rise), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);

    tick();
    rst_n = 1'b1;
    tick();

    a = 4'b0001;
    tick();
    a = '0;
    chk("reg_f_r", 32'(f_r), 32'h1);
    chk("reg_rise", 32'(rise), 32'h1);
    chk("reg_cnt", 32'(cnt), 32'h1);
    tick();
    chk("reg_rise_once", 32'(rise), 32'h0);
    chk("reg_f_r_back", 32'(f_r), 32'h0);

    d = 4'b0001;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rise) rises++;
    end
    chk("sat_cnt", 32'(cnt), 32'd15);
    chk("sat_rises", 32'(rises), 32'd1);
    tick();
    chk("sat_hold", 32'(cnt), 32'd15);

    zero_ops();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    b = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_cnt", 32'(cnt), 32'd7);
    chk("pre_rst_f_r", 32'(f_r), 32'h1);
    #1;
    rst_n = 1'b0;
    a = 4'b1000;
    #1;
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_f_r", 32'(f_r), 32'h0);
    chk("arst_rise", 32'(rise), 32'h0);
    chk("arst_f_live", 32'(f), 32'b1001);
    a = '0;
    rst_n = 1'b1;
    tick();
    chk("rel_rise", 32'(rise), 32'h1);
    chk("rel_cnt", 32'(cnt), 32'h1);

    zero_ops();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    c = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_clr_cnt", 32'(cnt), 32'd5);
    clr = 1'b1;
    tick();
    chk("clr_cnt", 32'(cnt), 32'h0);
    chk("clr_rise", 32'(rise), 32'h0);
    clr = 1'b0;
    tick();
    chk("post_clr_rise", 32'(rise), 32'h1);
    chk("post_clr_cnt", 32'(cnt), 32'h1);

    a = 4'b0001; b = 4'b0010; c = 4'b0100; d = 4'b0000;
    #1;
    chk("vec_f", 32'(f), 32'b0111);
    chk("vec_any", 32'(any), 32'h1);
    zero_ops();
    #1;
    chk("vec0_f", 32'(f), 32'h0);
    chk("vec0_any", 32'(any), 32'h0);

    for (int i = 0; i < 400; i++) begin
      tick();
      a = ($urandom_range(3) == 0) ? W'($urandom) : '0;
      b = ($urandom_range(3) == 0) ? W'($urandom) : '0;
      c = ($urandom_range(5) == 0) ? W'($urandom) : '0;
      d = ($urandom_range(7) == 0) ? W'($urandom) : '0;
      {a1, b1, c1, d1} = 4'($urandom);
      clr = ($urandom_range(11) == 0);
      if ($urandom_range(49) == 0) begin
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
